// File: rtl/btn_pkg.sv
// Shared constants and types for the multi-channel button conditioner.
// Defaults assume a ~25 MHz system clock.
package btn_pkg;

  localparam int CLK_HZ = 25_000_000;

  localparam int DEF_COUNTER_BIT   = 16;
  localparam int DEF_COUNTER_VAL   = 50_000;
  localparam int DEF_REPEAT_BIT    = 24;
  localparam int DEF_REPEAT_DELAY  = 12_500_000;
  localparam int DEF_REPEAT_PERIOD = 2_500_000;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic rpt;
  } btn_ch_t;

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between the raw pins, the conditioner and the game FSM.
// master = conditioner, slave = pin driver / strobe consumer.
interface btn_debounce_multi_if #(
  parameter int NUM_BTN = 4
);

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;
  logic               btn_any_press;

  modport master (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat,
    output btn_any_press
  );

  modport slave (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat,
    input  btn_any_press
  );

endinterface

// File: rtl/btn_debounce_multi_ch.sv
// One button channel: 2-FF sync, symmetric debounce,
// registered press/release strobes and optional hold-to-repeat.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int COUNTER_BIT   = DEF_COUNTER_BIT,
  parameter int COUNTER_VAL   = DEF_COUNTER_VAL,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_BIT    = DEF_REPEAT_BIT,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    btn_i,
  output btn_ch_t ch_o
);

  if (COUNTER_VAL < 1 ||
      longint'(COUNTER_VAL) >= (longint'(1) << COUNTER_BIT))
  begin : g_bad_cv
    $error("COUNTER_VAL out of range");
  end

  if (REPEAT_EN != 0 &&
      (REPEAT_DELAY < 1 ||
       longint'(REPEAT_DELAY) >= (longint'(1) << REPEAT_BIT) ||
       REPEAT_PERIOD < 1 ||
       REPEAT_PERIOD > REPEAT_DELAY))
  begin : g_bad_rpt
    $error("REPEAT_DELAY/REPEAT_PERIOD out of range");
  end

  localparam logic [COUNTER_BIT-1:0] CV_M1 =
    COUNTER_BIT'(COUNTER_VAL - 1);

  logic                   meta_q;
  logic                   sync_q;
  logic                   stable_q, stable_d;
  logic [COUNTER_BIT-1:0] cnt_q, cnt_d;
  logic                   level_q;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   rpt_w;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CV_M1) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output stage lags stable_q by one edge so strobes are registered.
  always_comb begin
    press_d = stable_q & ~level_q;
    rel_d   = ~stable_q & level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      level_q  <= stable_q;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  if (REPEAT_EN != 0) begin : g_rpt
    localparam logic [REPEAT_BIT-1:0] RD_M1 =
      REPEAT_BIT'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_BIT-1:0] RELOAD =
      REPEAT_BIT'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REPEAT_BIT-1:0] rcnt_q, rcnt_d;
    logic                  rpt_q, rpt_d;

    // Counts cycles since the press strobe; gated by stable_q so
    // nothing fires on the release edge.
    always_comb begin
      rcnt_d = '0;
      rpt_d  = 1'b0;
      if (stable_q && level_q) begin
        if (rcnt_q == RD_M1) begin
          rpt_d  = 1'b1;
          rcnt_d = RELOAD;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + 1'b1;
        end else begin
          rcnt_d = rcnt_q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rcnt_q <= '0;
        rpt_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rpt_q  <= rpt_d;
      end
    end

    assign rpt_w = rpt_q;
  end else begin : g_no_rpt
    assign rpt_w = 1'b0;
  end

  assign ch_o.lvl   = level_q;
  assign ch_o.press = press_q;
  assign ch_o.rel   = rel_q;
  assign ch_o.rpt   = rpt_w;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner feeding the game FSM.
// NUM_BTN independent channels plus an any-press summary strobe.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int COUNTER_BIT   = DEF_COUNTER_BIT,
  parameter int COUNTER_VAL   = DEF_COUNTER_VAL,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_BIT    = DEF_REPEAT_BIT,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic                  clk,
  input logic                  reset,
  btn_debounce_multi_if.master bus
);

  btn_ch_t            ch_out [NUM_BTN];
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] prs;
  logic [NUM_BTN-1:0] rel;
  logic [NUM_BTN-1:0] rpt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .COUNTER_BIT   (COUNTER_BIT),
      .COUNTER_VAL   (COUNTER_VAL),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_BIT    (REPEAT_BIT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .btn_i (bus.btn_in[i]),
      .ch_o  (ch_out[i])
    );

    assign lvl[i] = ch_out[i].lvl;
    assign prs[i] = ch_out[i].press;
    assign rel[i] = ch_out[i].rel;
    assign rpt[i] = ch_out[i].rpt;
  end

  assign bus.btn_level     = lvl;
  assign bus.btn_press     = prs;
  assign bus.btn_release   = rel;
  assign bus.btn_repeat    = rpt;
  assign bus.btn_any_press = |prs;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi with short debounce/repeat
// timings; a second instance has auto-repeat disabled.
module tb_btn_debounce_multi;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  btn_debounce_multi_if #(.NUM_BTN(4)) bus ();
  btn_debounce_multi_if #(.NUM_BTN(4)) bus_nr ();

  assign bus_nr.btn_in = bus.btn_in;

  btn_debounce_multi #(
    .NUM_BTN       (4),
    .COUNTER_BIT   (16),
    .COUNTER_VAL   (4),
    .REPEAT_EN     (1),
    .REPEAT_BIT    (24),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  btn_debounce_multi #(
    .NUM_BTN       (4),
    .COUNTER_BIT   (16),
    .COUNTER_VAL   (4),
    .REPEAT_EN     (0),
    .REPEAT_BIT    (24),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) u_norep (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    bus.btn_in = 4'b0000;
    repeat (12) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.btn_in = 4'b0000;
    repeat (3) step();
    n_vec++;
    if (bus.btn_level !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_level got=%b exp=0000", bus.btn_level);
    end
    n_vec++;
    if (bus.btn_press !== 4'b0000 || bus.btn_any_press !== 1'b0) begin
      n_err++;
      $display("FAIL reset_press got=%b/%b exp=0000/0",
               bus.btn_press, bus.btn_any_press);
    end
    n_vec++;
    if (bus.btn_release !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release got=%b exp=0000", bus.btn_release);
    end
    n_vec++;
    if (bus.btn_repeat !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_repeat got=%b exp=0000", bus.btn_repeat);
    end
    n_vec++;
    if (bus_nr.btn_level !== 4'b0000 || bus_nr.btn_repeat !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_norep got=%b/%b exp=0000/0000",
               bus_nr.btn_level, bus_nr.btn_repeat);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep, er;
    bus.btn_in = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      el = (k >= 6) ? 4'b0001 : 4'b0000;
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el) begin
        n_err++;
        $display("FAIL press_level k=%0d got=%b exp=%b", k, bus.btn_level, el);
      end
      n_vec++;
      if (bus.btn_press !== ep || bus.btn_any_press !== (k == 6)) begin
        n_err++;
        $display("FAIL press_strobe k=%0d got=%b/%b exp=%b/%b",
                 k, bus.btn_press, bus.btn_any_press, ep, (k == 6));
      end
    end
    bus.btn_in = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step();
      el = (k < 6) ? 4'b0001 : 4'b0000;
      er = (k == 6) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el || bus.btn_release !== er) begin
        n_err++;
        $display("FAIL release_ch0 k=%0d got=%b/%b exp=%b/%b",
                 k, bus.btn_level, bus.btn_release, el, er);
      end
    end
    drop_all();
  endtask

  task automatic test_bounce();
    logic [3:0] el, ep;
    for (int k = 0; k < 14; k++) begin
      bus.btn_in = (k == 3) ? 4'b0000 : 4'b0010;
      step();
      el = (k >= 10) ? 4'b0010 : 4'b0000;
      ep = (k == 10) ? 4'b0010 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el || bus.btn_press !== ep ||
          bus.btn_release !== 4'b0000) begin
        n_err++;
        $display("FAIL bounce k=%0d got=%b/%b/%b exp=%b/%b/0000",
                 k, bus.btn_level, bus.btn_press, bus.btn_release, el, ep);
      end
    end
    drop_all();
  endtask

  task automatic test_hold_repeat();
    logic [3:0] el, ep, er, eq;
    bus.btn_in = 4'b0100;
    for (int k = 0; k < 52; k++) begin
      bus.btn_in = (k < 35) ? 4'b0100 : 4'b0000;
      step();
      el = (k >= 6 && k < 41) ? 4'b0100 : 4'b0000;
      ep = (k == 6) ? 4'b0100 : 4'b0000;
      er = (k == 41) ? 4'b0100 : 4'b0000;
      eq = (k >= 16 && k < 41 && (k - 16) % 3 == 0) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el || bus.btn_press !== ep ||
          bus.btn_release !== er) begin
        n_err++;
        $display("FAIL hold_lpr k=%0d got=%b/%b/%b exp=%b/%b/%b",
                 k, bus.btn_level, bus.btn_press, bus.btn_release,
                 el, ep, er);
      end
      n_vec++;
      if (bus.btn_repeat !== eq) begin
        n_err++;
        $display("FAIL hold_repeat k=%0d got=%b exp=%b",
                 k, bus.btn_repeat, eq);
      end
      n_vec++;
      if (bus_nr.btn_repeat !== 4'b0000 || bus_nr.btn_level !== el) begin
        n_err++;
        $display("FAIL norep k=%0d got=%b/%b exp=0000/%b",
                 k, bus_nr.btn_repeat, bus_nr.btn_level, el);
      end
    end
    drop_all();
  endtask

  task automatic test_release_glitch();
    logic [3:0] el, ep;
    for (int k = 0; k < 24; k++) begin
      bus.btn_in = (k == 9 || k == 10) ? 4'b0000 : 4'b1000;
      step();
      el = (k >= 6) ? 4'b1000 : 4'b0000;
      ep = (k == 6) ? 4'b1000 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el || bus.btn_press !== ep ||
          bus.btn_release !== 4'b0000) begin
        n_err++;
        $display("FAIL glitch k=%0d got=%b/%b/%b exp=%b/%b/0000",
                 k, bus.btn_level, bus.btn_press, bus.btn_release, el, ep);
      end
    end
    drop_all();
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep;
    bus.btn_in = 4'b1001;
    for (int k = 0; k < 9; k++) begin
      step();
      ep = (k == 6) ? 4'b1001 : 4'b0000;
      n_vec++;
      if (bus.btn_press !== ep || bus.btn_any_press !== (k == 6)) begin
        n_err++;
        $display("FAIL simul k=%0d got=%b/%b exp=%b/%b",
                 k, bus.btn_press, bus.btn_any_press, ep, (k == 6));
      end
    end
    drop_all();
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] el, ep, eq;
    bus.btn_in = 4'b0100;
    for (int k = 0; k < 18; k++) begin
      step();
      if (k == 16) begin
        n_vec++;
        if (bus.btn_repeat !== 4'b0100) begin
          n_err++;
          $display("FAIL rst_pre_repeat got=%b exp=0100", bus.btn_repeat);
        end
      end
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (bus.btn_level !== 4'b0000 || bus.btn_press !== 4'b0000 ||
        bus.btn_release !== 4'b0000 || bus.btn_repeat !== 4'b0000 ||
        bus.btn_any_press !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got=%b/%b/%b/%b/%b exp=all0",
               bus.btn_level, bus.btn_press, bus.btn_release,
               bus.btn_repeat, bus.btn_any_press);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      el = (k >= 6) ? 4'b0100 : 4'b0000;
      ep = (k == 6) ? 4'b0100 : 4'b0000;
      eq = (k >= 16 && (k - 16) % 3 == 0) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (bus.btn_level !== el || bus.btn_press !== ep ||
          bus.btn_repeat !== eq || bus.btn_release !== 4'b0000) begin
        n_err++;
        $display("FAIL rst_after k=%0d got=%b/%b/%b/%b exp=%b/%b/%b/0000",
                 k, bus.btn_level, bus.btn_press, bus.btn_repeat,
                 bus.btn_release, el, ep, eq);
      end
    end
    drop_all();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.btn_in = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
